// File: rtl/reg_file_pkg.sv
// Shared types and sizing for the RV32 register file and its pending-write scoreboard.
package reg_file_pkg;

    localparam int unsigned NUM_REGS     = 32;
    localparam int unsigned RegWidth     = 32;
    localparam int unsigned RegAddrWidth = $clog2(NUM_REGS);

    localparam int unsigned CNT_WIDTH = 2;
    localparam int unsigned CNT_MAX   = (1 << CNT_WIDTH) - 1;

    typedef logic [CNT_WIDTH-1:0] sb_cnt_t;

    typedef struct packed {
        logic [RegWidth-1:0]     value;
        logic [RegAddrWidth-1:0] addr;
    } reg_transport_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register outstanding-write counters with issue/writeback arbitration, busy and full flags.
// Busy look-ahead on a same-cycle writeback is enabled by REG_FILE_SB_BYPASS_EN.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned NumRegs  = NUM_REGS,
    parameter int unsigned CntWidth = CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic [RegAddrWidth-1:0] issue_rd,
    input  logic                    wb_valid,
    input  logic [RegAddrWidth-1:0] wb_addr,
    input  logic [RegAddrWidth-1:0] rs1_addr,
    input  logic [RegAddrWidth-1:0] rs2_addr,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic                    issue_full
);

    logic [CntWidth-1:0] cnt_q [NumRegs];
    logic [CntWidth-1:0] cnt_d [NumRegs];
    logic [NumRegs-1:0]  inc_vec;
    logic [NumRegs-1:0]  dec_vec;

    assign issue_full = (issue_rd != '0) && (cnt_q[issue_rd] == '1);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < int'(NumRegs); i++) begin
            cnt_d[i] = cnt_q[i];
        end
        // Entry 0 is never touched so x0 can never appear busy.
        for (int i = 1; i < int'(NumRegs); i++) begin
            inc_vec[i] = issue_valid && !issue_full && (issue_rd == RegAddrWidth'(i));
            dec_vec[i] = wb_valid && (wb_addr == RegAddrWidth'(i)) && (cnt_q[i] != '0);
            if (inc_vec[i] && !dec_vec[i]) begin
                cnt_d[i] = cnt_q[i] + CntWidth'(1);
            end else if (dec_vec[i] && !inc_vec[i]) begin
                cnt_d[i] = cnt_q[i] - CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        rs1_busy = (rs1_addr != '0) && (cnt_q[rs1_addr] != '0);
        rs2_busy = (rs2_addr != '0) && (cnt_q[rs2_addr] != '0);
`ifdef REG_FILE_SB_BYPASS_EN
        // Last outstanding write retiring this cycle: operand is already available via forwarding.
        if (dec_vec[rs1_addr] && !inc_vec[rs1_addr] && (cnt_q[rs1_addr] == CntWidth'(1))) begin
            rs1_busy = 1'b0;
        end
        if (dec_vec[rs2_addr] && !inc_vec[rs2_addr] && (cnt_q[rs2_addr] == CntWidth'(1))) begin
            rs2_busy = 1'b0;
        end
`endif
    end

`ifndef SYNTHESIS
    wb_has_pending: assert property (@(posedge clk) disable iff (rst)
        (wb_valid && (wb_addr != '0)) |-> (cnt_q[wb_addr] != '0));
`endif

endmodule

// File: rtl/reg_file_sb.sv
// RV32 integer register file with pending-write scoreboard; x0 hardwired to zero.
// Same-cycle writeback forwarding to the read ports is enabled by REG_FILE_SB_BYPASS_EN.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int unsigned NumRegs  = NUM_REGS,
    parameter int unsigned CntWidth = CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  reg_transport_t          i_wb,
    input  logic                    i_wb_valid,
    input  logic [RegAddrWidth-1:0] i_rs1_addr,
    input  logic [RegAddrWidth-1:0] i_rs2_addr,
    output logic [RegWidth-1:0]     o_rs1_value,
    output logic [RegWidth-1:0]     o_rs2_value,
    output logic                    o_rs1_busy,
    output logic                    o_rs2_busy,
    input  logic                    i_issue_valid,
    input  logic [RegAddrWidth-1:0] i_issue_rd,
    output logic                    o_issue_full
);

    logic [RegWidth-1:0] regs_q [NumRegs];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                regs_q[i] <= '0;
            end
        end else if (i_wb_valid && (i_wb.addr != '0)) begin
            regs_q[i_wb.addr] <= i_wb.value;
        end
    end

    always_comb begin
        o_rs1_value = regs_q[i_rs1_addr];
        o_rs2_value = regs_q[i_rs2_addr];
`ifdef REG_FILE_SB_BYPASS_EN
        if (i_wb_valid && (i_wb.addr == i_rs1_addr)) begin
            o_rs1_value = i_wb.value;
        end
        if (i_wb_valid && (i_wb.addr == i_rs2_addr)) begin
            o_rs2_value = i_wb.value;
        end
`endif
        // Applied last so forwarding can never leak a value onto x0.
        if (i_rs1_addr == '0) begin
            o_rs1_value = '0;
        end
        if (i_rs2_addr == '0) begin
            o_rs2_value = '0;
        end
    end

    reg_scoreboard #(
        .NumRegs  (NumRegs),
        .CntWidth (CntWidth)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (i_issue_valid),
        .issue_rd    (i_issue_rd),
        .wb_valid    (i_wb_valid),
        .wb_addr     (i_wb.addr),
        .rs1_addr    (i_rs1_addr),
        .rs2_addr    (i_rs2_addr),
        .rs1_busy    (o_rs1_busy),
        .rs2_busy    (o_rs2_busy),
        .issue_full  (o_issue_full)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed scenarios plus random traffic against an array model.
module tb_reg_file_sb;
    import reg_file_pkg::*;

    typedef struct {
        logic [31:0] v1;
        logic [31:0] v2;
        logic        b1;
        logic        b2;
        logic        full;
    } exp_t;

    logic           clk;
    logic           rst;
    reg_transport_t i_wb;
    logic           i_wb_valid;
    logic [4:0]     i_rs1_addr;
    logic [4:0]     i_rs2_addr;
    logic [31:0]    o_rs1_value;
    logic [31:0]    o_rs2_value;
    logic           o_rs1_busy;
    logic           o_rs2_busy;
    logic           i_issue_valid;
    logic [4:0]     i_issue_rd;
    logic           o_issue_full;

    reg_file_sb dut (
        .clk           (clk),
        .rst           (rst),
        .i_wb          (i_wb),
        .i_wb_valid    (i_wb_valid),
        .i_rs1_addr    (i_rs1_addr),
        .i_rs2_addr    (i_rs2_addr),
        .o_rs1_value   (o_rs1_value),
        .o_rs2_value   (o_rs2_value),
        .o_rs1_busy    (o_rs1_busy),
        .o_rs2_busy    (o_rs2_busy),
        .i_issue_valid (i_issue_valid),
        .i_issue_rd    (i_issue_rd),
        .o_issue_full  (o_issue_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural values and outstanding-write counts.
    logic [31:0] mem [32];
    int          cnt [32];
    exp_t        expq [$];
    logic        check_en;
    int          n_checks;
    int          n_fail;
    int          cyc;

`ifdef REG_FILE_SB_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            if (expq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL queue_underflow cycle %0d: got empty queue expected an entry", cyc);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("rs1_value", o_rs1_value, e.v1);
                chk("rs2_value", o_rs2_value, e.v2);
                chk("rs1_busy", 32'(o_rs1_busy), 32'(e.b1));
                chk("rs2_busy", 32'(o_rs2_busy), 32'(e.b2));
                chk("issue_full", 32'(o_issue_full), 32'(e.full));
            end
        end
    end

    function automatic logic [31:0] exp_val(input logic [4:0] a, input logic wbv,
                                            input logic [4:0] wa, input logic [31:0] wv);
        if (a == 0) return 32'h0;
        if (Bypass && wbv && wa == a) return wv;
        return mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input logic wbv, input logic [4:0] wa,
                                      input logic inc_hit);
        if (a == 0 || cnt[a] == 0) return 1'b0;
        // With forwarding, the final pending write landing now releases the operand.
        if (Bypass && wbv && wa == a && cnt[a] == 1 && !inc_hit) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'h0;
            cnt[i] = 0;
        end
    endtask

    task automatic cycle(input logic r, input logic wbv, input logic [4:0] wa,
                         input logic [31:0] wv, input logic iv, input logic [4:0] rd,
                         input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        logic full;
        logic inc;
        int   pre;
        rst           = r;
        i_wb_valid    = wbv;
        i_wb.addr     = wa;
        i_wb.value    = wv;
        i_issue_valid = iv;
        i_issue_rd    = rd;
        i_rs1_addr    = a1;
        i_rs2_addr    = a2;
        full   = (rd != 0) && (cnt[rd] == int'(CNT_MAX));
        inc    = iv && (rd != 0) && !full;
        e.v1   = exp_val(a1, wbv, wa, wv);
        e.v2   = exp_val(a2, wbv, wa, wv);
        e.b1   = exp_busy(a1, wbv, wa, inc && rd == a1);
        e.b2   = exp_busy(a2, wbv, wa, inc && rd == a2);
        e.full = full;
        expq.push_back(e);
        check_en = 1'b1;
        @(posedge clk);
        if (r) begin
            model_clear();
        end else begin
            pre = cnt[wa];
            if (inc) cnt[rd]++;
            if (wbv && wa != 0) begin
                mem[wa] = wv;
                if (pre > 0) cnt[wa]--;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pend [$];
        logic        wbv;
        logic [4:0]  wa;
        logic [4:0]  rd;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        check_en = 1'b0;
        rst = 1'b1;
        i_wb = '0;
        i_wb_valid = 1'b0;
        i_issue_valid = 1'b0;
        i_issue_rd = '0;
        i_rs1_addr = '0;
        i_rs2_addr = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;

        // Reset state on x5 and x0.
        cycle(0, 0, 0, 0, 0, 5, 5, 0);
        // Single issue then writeback to x5.
        cycle(0, 0, 0, 0, 1, 5, 5, 0);
        cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
        cycle(0, 0, 0, 0, 0, 0, 5, 5);
        // Saturate x7, drop a fourth issue, then drain.
        repeat (3) cycle(0, 0, 0, 0, 1, 7, 7, 0);
        cycle(0, 0, 0, 0, 1, 7, 7, 7);
        for (int k = 0; k < 3; k++) cycle(0, 1, 7, 32'h7000_0000 + k, 0, 7, 7, 0);
        cycle(0, 0, 0, 0, 0, 7, 7, 7);
        // Same-cycle issue and writeback on x9.
        cycle(0, 0, 0, 0, 1, 9, 9, 0);
        cycle(0, 1, 9, 32'h0909_0909, 1, 9, 9, 0);
        cycle(0, 0, 0, 0, 0, 9, 9, 9);
        cycle(0, 1, 9, 32'h9999_0000, 0, 0, 9, 0);
        // Writes to x0 are discarded and never forwarded.
        cycle(0, 1, 0, 32'h1234, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        // Writeback to x3 observed in the write cycle and the next.
        cycle(0, 0, 0, 0, 1, 3, 3, 3);
        cycle(0, 1, 3, 32'hA5A5A5A5, 0, 0, 3, 0);
        cycle(0, 0, 0, 0, 0, 0, 3, 3);
        // Mid-operation reset discards same-cycle issue and writeback.
        cycle(0, 0, 0, 0, 1, 4, 4, 0);
        cycle(1, 1, 4, 32'h4444_4444, 1, 6, 4, 6);
        cycle(0, 0, 0, 0, 0, 6, 4, 6);

        for (int n = 0; n < 600; n++) begin
            pend.delete();
            for (int i = 1; i < 32; i++) if (cnt[i] > 0) pend.push_back(i);
            wbv = 1'b0;
            wa  = 5'd0;
            if (pend.size() > 0 && $urandom_range(0, 9) < 6) begin
                wbv = 1'b1;
                wa  = 5'(pend[$urandom_range(0, pend.size() - 1)]);
            end else if ($urandom_range(0, 9) == 0) begin
                wbv = 1'b1;
            end
            rd = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            cycle(($urandom_range(0, 99) == 0), wbv, wa, $urandom, $urandom_range(0, 1), rd,
                  ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) == 1) ? rd : 5'($urandom_range(0, 7)));
        end

        check_en = 1'b0;
        i_wb_valid = 1'b0;
        i_issue_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d entries left expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- RV32 integer register file with a per-register pending-write scoreboard.
- Sits directly downstream of the writeback stage. Consumes the reg_transport_t writeback bundle (value + addr) and commits it to architectural state.
- Serves two combinational read ports to decode, plus per-operand busy flags for the issue/hazard logic.
- x0 is hardwired to zero.

Parameters:
- NUM_REGS, 32, number of architectural registers (power of two; address width = RegAddrWidth).
- CNT_WIDTH, 2, width of each per-register outstanding-write counter (max outstanding = 2^CNT_WIDTH-1).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_wb  in  RegWidth+RegAddrWidth (reg_transport_t)  writeback bundle
- i_wb_valid  in  1  i_wb is a valid commit this cycle
- i_rs1_addr  in  RegAddrWidth  read port 1 address
- i_rs2_addr  in  RegAddrWidth  read port 2 address
- o_rs1_value  out  RegWidth  read port 1 data
- o_rs2_value  out  RegWidth  read port 2 data
- o_rs1_busy  out  1  rs1 has at least one outstanding write
- o_rs2_busy  out  1  rs2 has at least one outstanding write
- i_issue_valid  in  1  an instruction writing i_issue_rd is issued this cycle
- i_issue_rd  in  RegAddrWidth  destination of issued instruction
- o_issue_full  out  1  i_issue_rd counter saturated; issuer must not issue

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: all registers 0, all counters 0. After reset both read ports return 0, busy flags are 0 and o_issue_full is 0.
- Write: on a rising edge with i_wb_valid=1 and i_wb.addr!=0, the register at addr takes i_wb.value. Writes to addr 0 are discarded.
- Read: combinational, zero latency. Address 0 always returns 0 and busy=0.
- Scoreboard counters (addr 0 never counts):
  - inc when i_issue_valid && i_issue_rd!=0 && !o_issue_full.
  - dec when i_wb_valid && i_wb.addr!=0 && counter!=0.
  - inc and dec on the same register in the same cycle: counter unchanged.
  - dec at 0: ignored, and the counter stays 0 (no underflow). The optional assertion below flags this case.
  - inc at max: blocked by o_issue_full; an issue presented while full is dropped (no change).
- o_rsN_busy = (counter[rsN]!=0). It is combinational from current state and does not look ahead to a same-cycle writeback.
- o_issue_full = (counter[i_issue_rd]==max) && i_issue_rd!=0. Combinational.
- Reset asserted mid-operation: clears everything on that edge. A same-cycle writeback or issue is discarded.
- Writeback and issue to different registers in the same cycle: both take effect independently.

Optional Feature:
- Macro: REG_FILE_SB_BYPASS_EN.
- Defined:
  - If i_wb_valid && i_wb.addr==rsN && rsN!=0, o_rsN_value = i_wb.value in the same cycle (write-through).
  - o_rsN_busy is additionally cleared when counter[rsN]==1 and that same-cycle writeback decrements it.
- Undefined:
  - Reads return the pre-write stored value during the write cycle.
  - Busy reflects the registered counter only.
- Simulation-only: an assertion fires on any writeback to a nonzero register whose counter is 0.

Decomposition:
- Shared package reg_file_pkg:
  - NUM_REGS default constant.
  - CNT_WIDTH and the derived max-count localparam.
  - typedef sb_cnt_t (logic [CNT_WIDTH-1:0]).
  - Reuses reg_transport_t and RegWidth/RegAddrWidth from the existing packages.
- One sub-module, reg_scoreboard: owns the counter array, inc/dec arbitration, busy and full outputs.
- The data array, read muxes and bypass stay in reg_file_sb.

Test Plan:
- Reset then read x5 and x0 -> both values 0, busy 0, o_issue_full 0.
- Issue rd=5. Next cycle wb {addr=5, value=0xDEADBEEF} -> o_rs1_busy(rs1=5)=1 after issue. After the wb edge, value=0xDEADBEEF and busy=0.
- Issue rd=7 three times -> o_issue_full=1. A fourth issue is dropped. Three wbs to 7 return the counter to 0, and busy falls after the third.
- Same cycle: issue rd=9 with counter[9]=1, and wb addr=9 -> counter stays 1, busy stays 1, and x9 is updated.
- wb {addr=0, value=0x1234} -> x0 still reads 0. With bypass enabled, rs1=0 does not forward.
- Bypass enabled: wb {addr=3, value=0xA5A5A5A5} with rs1=3 -> o_rs1_value=0xA5A5A5A5 the same cycle. Disabled: the old value that cycle, and the new value the next cycle.
